// File: rtl/uart_pkg.sv
// uart_pkg: shared types and uart_tx handshake constants for the transmit path.
package uart_pkg;
   typedef logic [7:0] byte_t;
   typedef enum logic [1:0] {S_ARB, S_WAIT, S_CONT} arb_state_t;
   localparam int BYTE_W = 8;
   localparam logic TX_IDLE = 1'b0;
   localparam logic TX_SEND = 1'b1;
   function automatic int rr_wrap(int p, int k, int n);
      return (p + k >= n) ? p + k - n : p + k;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin picker; first requester at or after rr_ptr, wrapping modulo NREQ.
module rr_pick
   import uart_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] rr_ptr,
   output logic [$clog2(NREQ)-1:0] grant,
   output logic                    any_valid
);
   localparam int PW = $clog2(NREQ);
   // Scan farthest-first so the nearest valid requester overwrites earlier picks.
   always_comb begin
      grant = '0;
      for (int k = NREQ - 1; k >= 0; k--)
         if (req[rr_wrap(int'(rr_ptr), k, NREQ)]) grant = PW'(rr_wrap(int'(rr_ptr), k, NREQ));
   end
   assign any_valid = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among NREQ requesters, round-robin with bounded bursts.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int MAX_BURST   = 16,
   parameter int HOLD_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*8-1:0]       req_data,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         req_ready,
   output logic                    tx_valid,
   output logic [7:0]              tx_data,
   input  logic                    tx_done,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    owner_valid,
   output logic                    busy
);
   localparam int PW = $clog2(NREQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   arb_state_t    state;
   logic [PW-1:0] rr_ptr, grant, sel, nxt_ptr;
   logic [BW-1:0] beat_cnt;
   logic [HW-1:0] hold_cnt;
   logic          last_flag, any_valid, accept;
   byte_t         req_byte;
   rr_pick #(.NREQ(NREQ)) u_pick (
      .req       (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .any_valid (any_valid)
   );
   // Ready is forced low during reset so nothing is accepted while the transmitter is held.
   always_comb begin
      sel       = (state == S_CONT) ? owner : grant;
      req_ready = !rstn ? '0
                : (state == S_ARB)  ? ({{(NREQ-1){1'b0}}, any_valid} << grant)
                : (state == S_CONT) ? (req_valid & (NREQ'(1) << owner))
                : '0;
   end
   assign accept   = |(req_valid & req_ready);
   assign req_byte = req_data[int'(sel)*BYTE_W +: BYTE_W];
   assign nxt_ptr  = PW'(rr_wrap(int'(owner), 1, NREQ));
   assign busy     = state == S_WAIT;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= S_ARB;
         rr_ptr      <= '0;
         owner       <= '0;
         owner_valid <= 1'b0;
         tx_valid    <= TX_IDLE;
         tx_data     <= '0;
         beat_cnt    <= '0;
         hold_cnt    <= '0;
         last_flag   <= 1'b0;
      end else begin
         tx_valid <= TX_IDLE;
         if (accept) begin
            tx_data     <= req_byte;
            tx_valid    <= TX_SEND;
            owner       <= sel;
            owner_valid <= 1'b1;
            beat_cnt    <= beat_cnt + 1'b1;
            last_flag   <= req_last[sel] | (beat_cnt == BW'(MAX_BURST - 1));
            state       <= S_WAIT;
         end else if (state == S_WAIT && tx_done) begin
            if (last_flag) begin
               state       <= S_ARB;
               rr_ptr      <= nxt_ptr;
               beat_cnt    <= '0;
               owner_valid <= 1'b0;
            end else begin
               state    <= S_CONT;
               hold_cnt <= '0;
            end
         end else if (state == S_CONT) begin
            if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
               state       <= S_ARB;
               rr_ptr      <= nxt_ptr;
               beat_cnt    <= '0;
               owner_valid <= 1'b0;
            end else begin
               hold_cnt <= hold_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner sequences and queue-model scenarios.
module tb_uart_tx_arbiter;
   localparam int N = 4, MB = 16, HC = 255, LIMIT = 20000;
   logic clk = 1'b0, rstn = 1'b0, tx_done = 1'b0;
   logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
   logic [N*8-1:0] req_data = '0;
   logic tx_valid, owner_valid, busy;
   logic [7:0] tx_data;
   logic [1:0] owner;
   int errs = 0, checks = 0;
   typedef struct { logic [3:0] v; logic [3:0] r; } vec_t;
   vec_t tbl[7];
   logic [8:0] q[N][$];
   logic [9:0] expq[$];
   uart_tx_arbiter #(.NREQ(N), .MAX_BURST(MB), .HOLD_CYCLES(HC)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_done(tx_done),
      .owner(owner), .owner_valid(owner_valid), .busy(busy)
   );
   always #5 clk = ~clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic do_reset();
      rstn = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_done = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
   endtask
   task automatic set_req(int i, logic [7:0] d, logic l);
      req_valid[i] = 1'b1; req_data[i*8 +: 8] = d; req_last[i] = l;
   endtask
   task automatic pulse_done();
      @(posedge clk); #1 tx_done = 1'b1;
      @(posedge clk); #1 tx_done = 1'b0;
   endtask
   task automatic drive_heads();
      logic [8:0] h;
      for (int i = 0; i < N; i++)
         if (q[i].size() > 0) begin
            h = q[i][0];
            set_req(i, h[7:0], h[8]);
         end else begin
            req_valid[i] = 1'b0; req_last[i] = 1'b0;
         end
   endtask
   // Expected transmit order from queue contents: round-robin owners, burst ends on last or MAX_BURST.
   task automatic build_model();
      logic [8:0] mq[N][$];
      logic [8:0] h;
      int rr = 0, pick, n;
      expq.delete();
      for (int i = 0; i < N; i++) mq[i] = q[i];
      forever begin
         pick = -1;
         for (int k = N - 1; k >= 0; k--) if (mq[(rr + k) % N].size() > 0) pick = (rr + k) % N;
         if (pick < 0) break;
         n = 0;
         do begin
            h = mq[pick].pop_front();
            expq.push_back({2'(pick), h[7:0]});
            n++;
         end while (!h[8] && n < MB && mq[pick].size() > 0);
         rr = (pick + 1) % N;
      end
   endtask
   task automatic run_scenario(int lat_max);
      logic [N-1:0] fire;
      logic [9:0] e;
      logic [7:0] held = '0;
      int cd = 0, gap = -1, cyc = 0;
      bit inflight = 0;
      build_model();
      rstn = 1'b0; tx_done = 1'b0;
      drive_heads();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      while ((expq.size() > 0 || inflight || tx_done) && cyc < LIMIT) begin
         @(negedge clk);
         if (gap >= 0) gap++;
         fire = req_valid & req_ready;
         if (tx_valid) begin
            chk("tx_overlap", 32'(inflight), 0);
            if (gap > 0) chk("regrant_gap", 32'(gap), 3);
            gap = -1;
            if (expq.size() == 0) chk("extra_byte", 32'(tx_data), 32'hffff);
            else begin
               e = expq.pop_front();
               chk("tx_owner", 32'(owner), 32'(e[9:8]));
               chk("tx_byte", 32'(tx_data), 32'(e[7:0]));
            end
            held = tx_data; inflight = 1; cd = $urandom_range(lat_max, 1);
         end else if (inflight) chk("tx_hold", 32'(tx_data), 32'(held));
         @(posedge clk); #1;
         cyc++;
         tx_done = 1'b0;
         for (int i = 0; i < N; i++) if (fire[i]) void'(q[i].pop_front());
         drive_heads();
         if (inflight) begin
            cd--;
            if (cd == 0) begin tx_done = 1'b1; inflight = 0; gap = 0; end
         end
      end
      chk("scenario_done", 32'(cyc < LIMIT), 1);
   endtask
   initial begin
      tbl[0] = '{4'b0000, 4'b0000}; tbl[1] = '{4'b0100, 4'b0100}; tbl[2] = '{4'b1010, 4'b0010};
      tbl[3] = '{4'b1111, 4'b0001}; tbl[4] = '{4'b1000, 4'b1000}; tbl[5] = '{4'b0110, 4'b0010};
      tbl[6] = '{4'b1100, 4'b0100};
      req_valid = 4'hf;
      #12;
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_tx_valid", 32'(tx_valid), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_owner_valid", 32'(owner_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      do_reset();
      for (int k = 0; k < 7; k++) begin
         req_valid = tbl[k].v;
         #1 chk($sformatf("grant_vec%0d", k), 32'(req_ready), 32'(tbl[k].r));
         req_valid = '0;
         @(negedge clk);
      end
      // Single byte with a long transmitter: done lands in cycle 1740.
      do_reset();
      @(posedge clk); #1 set_req(2, 8'h41, 1'b1);
      #1 chk("t1_ready", 32'(req_ready), 32'h4);
      @(posedge clk); #1 req_valid = '0;
      chk("t1_tx_valid", 32'(tx_valid), 1);
      chk("t1_tx_data", 32'(tx_data), 32'h41);
      chk("t1_owner", 32'(owner), 2);
      chk("t1_busy", 32'(busy), 1);
      @(posedge clk); #1 chk("t1_pulse_end", 32'(tx_valid), 0);
      repeat (1738) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk); #1 tx_done = 1'b0;
      chk("t1_owner_valid", 32'(owner_valid), 0);
      chk("t1_busy_end", 32'(busy), 0);
      req_valid = 4'hf;
      #1 chk("t1_rr_ptr3", 32'(req_ready), 32'h8);
      req_valid = '0;
      // Hold timeout after one non-last byte.
      do_reset();
      @(posedge clk); #1 set_req(2, 8'h33, 1'b0);
      @(posedge clk); #1 req_valid = '0;
      pulse_done();
      begin
         int n = 0;
         while (owner_valid && !busy && n < 400) begin n++; @(posedge clk); #1; end
         chk("t5_hold_cycles", 32'(n), 255);
      end
      chk("t5_released", 32'(owner_valid), 0);
      req_valid = 4'hf;
      #1 chk("t5_rr_ptr3", 32'(req_ready), 32'h8);
      req_valid = '0;
      // Re-assert on the final hold cycle: the accept wins over the timeout.
      do_reset();
      @(posedge clk); #1 set_req(2, 8'h33, 1'b0);
      @(posedge clk); #1 req_valid = '0;
      pulse_done();
      repeat (254) @(posedge clk);
      #1 set_req(2, 8'h34, 1'b1);
      #1 chk("t5b_ready", 32'(req_ready), 32'h4);
      @(posedge clk); #1 req_valid = '0;
      chk("t5b_tx_valid", 32'(tx_valid), 1);
      chk("t5b_tx_data", 32'(tx_data), 32'h34);
      chk("t5b_owner_valid", 32'(owner_valid), 1);
      pulse_done();
      // Asynchronous reset while a byte is in flight.
      do_reset();
      @(posedge clk); #1 set_req(1, 8'h5a, 1'b1);
      @(posedge clk); #1 chk("t6_tx_valid", 32'(tx_valid), 1);
      #1 rstn = 1'b0;
      #1 chk("t6_rst_tx_valid", 32'(tx_valid), 0);
      chk("t6_rst_ready", 32'(req_ready), 0);
      chk("t6_rst_owner_valid", 32'(owner_valid), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      @(negedge clk); rstn = 1'b1; req_valid = '0; tx_done = 1'b1;
      @(negedge clk); tx_done = 1'b0;
      chk("t6_stray_busy", 32'(busy), 0);
      chk("t6_stray_owner_valid", 32'(owner_valid), 0);
      chk("t6_stray_tx_valid", 32'(tx_valid), 0);
      req_valid = 4'hf;
      #1 chk("t6_rr_ptr0", 32'(req_ready), 32'h1);
      req_valid = '0;
      set_req(1, 8'h77, 1'b1);
      #1 chk("t6_fresh_ready", 32'(req_ready), 32'h2);
      @(posedge clk); #1 req_valid = '0;
      chk("t6_fresh_data", 32'(tx_data), 32'h77);
      chk("t6_fresh_owner", 32'(owner), 1);
      pulse_done();
      // Round-robin over all four, then requester 0 again.
      for (int i = 0; i < N; i++) q[i].push_back({1'b1, 8'(8'h20 + i)});
      q[0].push_back({1'b1, 8'h24});
      run_scenario(4);
      // Burst of three from requester 1 while requester 0 keeps asking.
      q[0].push_back({1'b1, 8'h55}); q[0].push_back({1'b1, 8'h56});
      q[1].push_back({1'b0, 8'h10}); q[1].push_back({1'b0, 8'h11}); q[1].push_back({1'b1, 8'h12});
      run_scenario(5);
      // Twenty-byte stream is cut at MAX_BURST and resumes later.
      q[0].push_back({1'b1, 8'h01}); q[0].push_back({1'b1, 8'h02});
      for (int k = 0; k < 20; k++) q[3].push_back({k == 19, 8'(8'h80 + k)});
      run_scenario(3);
      for (int s = 0; s < 8; s++) begin
         for (int i = 0; i < N; i++) begin
            int n = $urandom_range((s % 2 == 0) ? 20 : 6, 0);
            for (int k = 0; k < n; k++)
               q[i].push_back({(k == n - 1) || ($urandom_range(3 + s, 0) == 0), 8'($urandom)});
         end
         run_scenario(1 + s);
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
